phy_rx_nlane: RTL and testbench

PHY_RX_NLANE -- requirements
Module: phy_rx_nlane

---
 rtl/phy_rx_nlane.sv | 149 ++++++++++++++
 tb/tb_phy_rx_nlane.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/phy_rx_nlane.sv
// Multi-lane serial receiver: per-lane COM byte alignment and lock, then lane-striped
// word assembly with skew and symbol-mismatch detection (sticky error).
module phy_rx_nlane #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned LOCK_COMS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANES-1:0]  serial_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic [LANES-1:0]  lane_lock,
  output logic              active_out,
  output logic              err_out
);

  localparam int unsigned GROUPS = WORD_W / (8 * LANES);
  localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [7:0]  Com    = 8'hBC;
  localparam logic [7:0]  Idle   = 8'h7C;

  typedef enum logic [1:0] {StSearch, StAlign, StLocked} state_e;

  state_e      state_q [LANES];
  state_e      state_d [LANES];
  logic [7:0]  sr_q    [LANES];
  logic [7:0]  sr_d    [LANES];
  logic [2:0]  cnt_q   [LANES];
  logic [2:0]  cnt_d   [LANES];
  logic [3:0]  com_q   [LANES];
  logic [3:0]  com_d   [LANES];
  logic [7:0]  nxt     [LANES];

  logic [LANES-1:0]  bnd, lock_w, is_com, is_idle, is_data;
  logic [WORD_W-1:0] asm_q, asm_d, data_q, data_d, word_w;
  logic [GW-1:0]     grp_q, grp_d;
  logic              valid_q, valid_d, err_q, err_d, active_w;
  int                base;

  // Per-lane alignment FSMs
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      nxt[i]     = {sr_q[i][6:0], serial_in[i]};
      sr_d[i]    = nxt[i];
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      com_d[i]   = com_q[i];
      bnd[i]     = (state_q[i] != StSearch) && (cnt_q[i] == 3'd7);
      lock_w[i]  = (state_q[i] == StLocked);
      is_com[i]  = (nxt[i] == Com);
      is_idle[i] = (nxt[i] == Idle);
      is_data[i] = !is_com[i] && !is_idle[i];
      unique case (state_q[i])
        StSearch: begin
          if (is_com[i]) begin
            state_d[i] = StAlign;
            cnt_d[i]   = 3'd0;
            com_d[i]   = 4'd1;
          end
        end
        StAlign: begin
          cnt_d[i] = cnt_q[i] + 3'd1;
          if (bnd[i]) begin
            if (is_com[i]) begin
              com_d[i] = com_q[i] + 4'd1;
              if (com_d[i] == LOCK_COMS[3:0]) state_d[i] = StLocked;
            end else begin
              state_d[i] = StSearch;
              com_d[i]   = 4'd0;
            end
          end
        end
        StLocked: cnt_d[i] = cnt_q[i] + 3'd1;
        default:  state_d[i] = StSearch;
      endcase
    end
  end

  assign active_w = &lock_w;

  // Word assembly across lanes at common byte boundaries
  always_comb begin
    word_w  = asm_q;
    base    = 0;
    asm_d   = asm_q;
    grp_d   = grp_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = err_q;
    for (int i = 0; i < LANES; i++) begin
      base = 8 * (int'(grp_q) * int'(LANES) + i);
      word_w[base +: 8] = nxt[i];
    end
    if (active_w && !err_q) begin
      if ((|bnd) && !(&bnd)) begin
        err_d = 1'b1;
      end else if (&bnd) begin
        if (&is_data) begin
          if (grp_q == GW'(GROUPS - 1)) begin
            data_d  = word_w;
            valid_d = 1'b1;
            grp_d   = '0;
          end else begin
            asm_d = word_w;
            grp_d = grp_q + GW'(1);
          end
        end else if (!(&is_com) && !(&is_idle)) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= StSearch;
        sr_q[i]    <= '0;
        cnt_q[i]   <= '0;
        com_q[i]   <= '0;
      end
      asm_q   <= '0;
      grp_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
        sr_q[i]    <= sr_d[i];
        cnt_q[i]   <= cnt_d[i];
        com_q[i]   <= com_d[i];
      end
      asm_q   <= asm_d;
      grp_q   <= grp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign lane_lock  = lock_w;
  assign active_out = active_w;
  assign err_out    = err_q;

endmodule

// File: tb/tb_phy_rx_nlane.sv
// Directed bench for phy_rx_nlane with LANES=2, WORD_W=32, LOCK_COMS=4.
module tb_phy_rx_nlane;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  serial_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic [1:0]  lane_lock;
  logic        active_out;
  logic        err_out;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;

  logic [55:0] s0, s1;

  phy_rx_nlane #(.LANES(2), .WORD_W(32), .LOCK_COMS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .lane_lock  (lane_lock),
    .active_out (active_out),
    .err_out    (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte per lane, MSB first; counts valid_out pulses seen after each edge.
  task automatic send(input logic [7:0] b0, input logic [7:0] b1);
    for (int j = 7; j >= 0; j--) begin
      serial_in = {b1[j], b0[j]};
      @(posedge clk);
      #1;
      if (valid_out) vcnt++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 64'(data_out), 64'h0);
    check({tag, "_valid"}, 64'(valid_out), 64'h0);
    check({tag, "_lock"}, 64'(lane_lock), 64'h0);
    check({tag, "_active"}, 64'(active_out), 64'h0);
    check({tag, "_err"}, 64'(err_out), 64'h0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("rst_pulse");
    reset = 1'b0;
  endtask

  task automatic lock_both();
    vcnt = 0;
    send(8'hBC, 8'hBC);
    send(8'hBC, 8'hBC);
    send(8'hBC, 8'hBC);
    check("lock_after3", 64'(lane_lock), 64'h0);
    send(8'hBC, 8'hBC);
    check("lock_after4", 64'(lane_lock), 64'h3);
    check("active_after4", 64'(active_out), 64'h1);
    check("no_valid_lock", 64'(vcnt), 64'h0);
  endtask

  initial begin
    reset     = 1'b1;
    serial_in = 2'b00;
    #12;
    check_reset_outputs("init");
    reset = 1'b0;

    lock_both();

    // Basic two-group word
    vcnt = 0;
    send(8'h11, 8'h22);
    check("g0_no_valid", 64'(vcnt), 64'h0);
    send(8'h33, 8'h44);
    check("w1_valid_now", 64'(valid_out), 64'h1);
    check("w1_valid_once", 64'(vcnt), 64'h1);
    check("w1_data", 64'(data_out), 64'h44332211);
    vcnt = 0;
    send(8'hBC, 8'hBC);
    check("com_skip_no_valid", 64'(vcnt), 64'h0);
    check("w1_data_held", 64'(data_out), 64'h44332211);

    // Distinct word, then IDLE between groups
    send(8'hA1, 8'hB2);
    send(8'hC3, 8'hD4);
    check("w2_data", 64'(data_out), 64'hD4C3B2A1);
    vcnt = 0;
    send(8'h11, 8'h22);
    send(8'h7C, 8'h7C);
    check("idle_no_valid", 64'(vcnt), 64'h0);
    check("idle_data_held", 64'(data_out), 64'hD4C3B2A1);
    send(8'h33, 8'h44);
    check("idle_valid_now", 64'(valid_out), 64'h1);
    check("idle_valid_once", 64'(vcnt), 64'h1);
    check("idle_word", 64'(data_out), 64'h44332211);
    check("idle_no_err", 64'(err_out), 64'h0);

    // Reset mid-word, relock, only the new word appears
    send(8'h11, 8'h22);
    pulse_reset();
    lock_both();
    vcnt = 0;
    send(8'hA5, 8'hB6);
    check("rst_g0_no_valid", 64'(vcnt), 64'h0);
    send(8'hC7, 8'hD8);
    check("rst_valid_now", 64'(valid_out), 64'h1);
    check("rst_new_word", 64'(data_out), 64'hD8C7B6A5);

    // Data on one lane, COM on the other
    send(8'h55, 8'hBC);
    check("mix_err", 64'(err_out), 64'h1);
    check("mix_data_kept", 64'(data_out), 64'hD8C7B6A5);
    vcnt = 0;
    send(8'h11, 8'h22);
    send(8'h33, 8'h44);
    check("mix_no_valid_after", 64'(vcnt), 64'h0);
    check("mix_err_sticky", 64'(err_out), 64'h1);
    check("mix_data_frozen", 64'(data_out), 64'hD8C7B6A5);

    // Lane1 delayed 3 bits: locks, then skewed boundaries
    pulse_reset();
    s0 = {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h11, 8'h33, 8'h00};
    s1 = {3'b000, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h22, 8'h44, 5'b00000};
    vcnt = 0;
    for (int c = 0; c < 56; c++) begin
      serial_in = {s1[55-c], s0[55-c]};
      @(posedge clk);
      #1;
      if (valid_out) vcnt++;
      if (c == 31) check("skew_lock_l0", 64'(lane_lock), 64'h1);
      if (c == 34) check("skew_lock_both", 64'(lane_lock), 64'h3);
      if (c == 38) check("skew_err_before", 64'(err_out), 64'h0);
      if (c == 39) check("skew_err_at", 64'(err_out), 64'h1);
    end
    check("skew_no_valid", 64'(vcnt), 64'h0);
    check("skew_err_held", 64'(err_out), 64'h1);
    check("skew_data_zero", 64'(data_out), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
